cmos_window_crop: RTL and testbench
===================================

// Module: cmos_window_crop
// PURPOSE
//  Runtime-configurable crop-and-decimate stage for the CMOS capture path, clocked by the camera pixel clock.
//  It selects a rectangular window, latched per frame, from the incoming pixel stream and keeps every 2^n-th pixel and line inside it.
//  It emits framing markers (sof/eol/eof) for the downstream frame-buffer writer.
//  It replaces fixed centred cropping and is placed between the camera byte-assembler and the write FIFO.
// PARAMETERS
//  DATA_W  16    pixel width in bits
//  CNT_W   12    width of the pixel/line counters and the cfg_* geometry fields
//  IN_W    1280  input active pixels per line; used for bounds checking
//  IN_H    720   input active lines per frame; used for bounds checking
//  DEF_X0  160   reset value of the active x0, y0, w and h registers
//  DEF_Y0  90    (centred 960x540 window)
//  DEF_W   960
//  DEF_H   540
// PORTS
//  cam_pclk        in   1       pixel clock; the only clock
//  rst_n           in   1       asynchronous, active-low reset
//  cam_vsync       in   1       frame sync; a rising edge starts a frame
//  cam_href        in   1       line sync; a falling edge ends a line
//  cam_data        in   DATA_W  pixel data
//  cam_data_valid  in   1       pixel strobe; gaps are allowed
//  cfg_x0, cfg_y0  in   CNT_W   window origin in input pixels and lines
//  cfg_w, cfg_h    in   CNT_W   window size in input pixels and lines
//  cfg_hdec        in   2       horizontal decimation exponent; step = 1<<cfg_hdec (1/2/4/8)
//  cfg_vdec        in   2       vertical decimation exponent
//  out_valid       out  1       output pixel strobe
//  out_data        out  DATA_W  output pixel; 0 whenever out_valid = 0
//  out_sof         out  1       high with the first output pixel of a frame
//  out_eol         out  1       high with the last output pixel of each line
//  out_eof         out  1       high with the last output pixel of a frame
//  out_width       out  CNT_W   output pixels per line = ((w-1)>>hdec)+1, from the active registers
//  cfg_err         out  1       the active window is illegal; the current frame is blanked
// BEHAVIOUR
//  - Edge detection:
//    - vsync and href each pass through 2 flops (d0, d1).
//    - pos_vs = d0 & ~d1.
//    - neg_hs = ~d0 & d1.
//  - h_cnt: cleared on pos_vs or neg_hs; else incremented on cam_data_valid; saturates at all-ones.
//  - v_cnt: cleared on pos_vs; else incremented on neg_hs; saturates at all-ones.
//  - Pixel coordinate: a valid beat has coordinate (h_cnt, v_cnt) as sampled in that cycle.
//  - Shadowing:
//    - On pos_vs, cfg_* are copied into the active registers; err, out_width, last_x and last_y are recomputed.
//    - cfg changes mid-frame have no effect until the next pos_vs.
//  - Error rule:
//    - err = (w==0) | (h==0) | (x0+w > IN_W) | (y0+h > IN_H).
//    - Sums are computed at CNT_W+1 bits, so there is no wrap.
//    - While err = 1, out_valid stays 0 for the whole frame.
//  - Keep rule: with dx = h_cnt - x0 and dy = v_cnt - y0, a pixel is kept when all of these hold:
//    - x0 <= h_cnt < x0+w
//    - y0 <= v_cnt < y0+h
//    - dx[hdec-1:0] == 0
//    - dy[vdec-1:0] == 0
//    - the block is armed
//    - err = 0
//    - cam_data_valid = 1
//  - Latency: exactly 1 cycle, input beat to registered outputs. Non-kept beats give out_valid = 0 and out_data = 0.
//  - Framing markers:
//    - last_x = ((w-1)>>hdec)<<hdec and last_y = ((h-1)>>vdec)<<vdec.
//    - out_eol = kept & dx == last_x.
//    - out_sof = kept & dx == 0 & dy == 0.
//    - out_eof = out_eol & dy == last_y.
//    - All markers are single-cycle and coincident with out_valid.
//  - Armed flag:
//    - Cleared by reset; set on the first pos_vs after reset.
//    - A reset mid-frame therefore produces no output until the next full frame starts.
//  - Reset values:
//    - All outputs 0, except out_width = ((DEF_W-1)>>0)+1.
//    - Active registers = DEF_*, with hdec = vdec = 0.
//    - Counters and sync flops 0.
//  - Simultaneous events:
//    - pos_vs wins over neg_hs for both counters.
//    - A valid beat in the same cycle as pos_vs/neg_hs is counted as pixel 0 of the new line.
//  - Frame truncation: a frame shorter than the window gives no out_eof. There is no recovery beyond the next pos_vs.
// TESTING
//  1. 1280x720 frame, cfg 160/90/960/540, dec 0/0:
//     - 960 out_valid per line, 540 lines.
//     - First pixel = input (160,90) with out_sof; 540 out_eol; 1 out_eof on pixel (1119,629).
//  2. Same window, hdec=1, vdec=1:
//     - 480 pixels per line (even dx), 270 lines, out_width = 480.
//     - eol at dx = 958; eof at dy = 538.
//  3. Change cfg_x0 from 160 to 0 mid-frame:
//     - The current frame still starts lines at x = 160.
//     - The next frame starts lines at x = 0.
//  4. cfg_x0 = 400, cfg_w = 960 (sum 1360 > 1280):
//     - cfg_err = 1 one cycle after pos_vs; zero out_valid for that frame.
//     - Restoring a legal cfg clears cfg_err at the next pos_vs.
//  5. Assert rst_n low mid-frame, release it mid-frame:
//     - All outputs are 0 during reset.
//     - No out_valid for the rest of that frame; normal output from the next frame.
//  6. cam_data_valid high every other cycle, with random 0-3 cycle gaps inside lines:
//     - Exactly the same set of kept pixels and markers as scenario 1.
//     - Each output lags its input by 1 cycle.

Source files
------------

// File: rtl/cmos_window_crop.sv
// cmos_window_crop: per-frame crop window with power-of-two decimation and sof/eol/eof framing
// Ports: cam_pclk/rst_n clock and async active-low reset; cam_vsync/cam_href/cam_data/cam_data_valid camera stream;
//        cfg_x0/y0/w/h/hdec/vdec window request, latched on each frame start;
//        out_valid/out_data/out_sof/out_eol/out_eof cropped stream (1-cycle latency);
//        out_width output pixels per line; cfg_err illegal active window (frame blanked).
module cmos_window_crop #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 12,
  parameter int IN_W   = 1280,
  parameter int IN_H   = 720,
  parameter int DEF_X0 = 160,
  parameter int DEF_Y0 = 90,
  parameter int DEF_W  = 960,
  parameter int DEF_H  = 540
) (
  input  logic              cam_pclk,
  input  logic              rst_n,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [DATA_W-1:0] cam_data,
  input  logic              cam_data_valid,
  input  logic [CNT_W-1:0]  cfg_x0,
  input  logic [CNT_W-1:0]  cfg_y0,
  input  logic [CNT_W-1:0]  cfg_w,
  input  logic [CNT_W-1:0]  cfg_h,
  input  logic [1:0]        cfg_hdec,
  input  logic [1:0]        cfg_vdec,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sof,
  output logic              out_eol,
  output logic              out_eof,
  output logic [CNT_W-1:0]  out_width,
  output logic              cfg_err
);
  localparam logic [CNT_W:0]   IN_W_L = (CNT_W+1)'(IN_W);
  localparam logic [CNT_W:0]   IN_H_L = (CNT_W+1)'(IN_H);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  logic vs_d0, vs_d1, hs_d0, hs_d1, pos_vs, neg_hs, armed, err;
  logic [CNT_W-1:0] h_cnt, v_cnt, x0, y0, w, h, last_x, last_y;
  logic [1:0] hdec, vdec;
  logic n_err, e_err, kept, eol;
  logic [CNT_W-1:0] n_lx, n_ly, n_ow, e_x0, e_y0, e_w, e_h, e_lx, e_ly, v_inc, hx, vy, dx, dy;
  logic [1:0] e_hdec, e_vdec;
  // In the pos_vs cycle the freshly requested window already applies, so a beat
  // landing there (pixel 0,0 of the new frame) sees the same geometry as the rest.
  always_comb begin
    pos_vs = vs_d0 & ~vs_d1;
    neg_hs = ~hs_d0 & hs_d1;
    n_err  = (cfg_w == '0) || (cfg_h == '0) ||
             (({1'b0, cfg_x0} + {1'b0, cfg_w}) > IN_W_L) ||
             (({1'b0, cfg_y0} + {1'b0, cfg_h}) > IN_H_L);
    n_lx   = ((cfg_w - ONE) >> cfg_hdec) << cfg_hdec;
    n_ly   = ((cfg_h - ONE) >> cfg_vdec) << cfg_vdec;
    n_ow   = ((cfg_w - ONE) >> cfg_hdec) + ONE;
    e_x0   = pos_vs ? cfg_x0 : x0;
    e_y0   = pos_vs ? cfg_y0 : y0;
    e_w    = pos_vs ? cfg_w : w;
    e_h    = pos_vs ? cfg_h : h;
    e_lx   = pos_vs ? n_lx : last_x;
    e_ly   = pos_vs ? n_ly : last_y;
    e_hdec = pos_vs ? cfg_hdec : hdec;
    e_vdec = pos_vs ? cfg_vdec : vdec;
    e_err  = pos_vs ? n_err : err;
    v_inc  = v_cnt + CNT_W'(~&v_cnt);
    // A beat coincident with a line/frame boundary is pixel 0 of the new line.
    hx     = (pos_vs | neg_hs) ? '0 : h_cnt;
    vy     = pos_vs ? '0 : neg_hs ? v_inc : v_cnt;
    dx     = hx - e_x0;
    dy     = vy - e_y0;
    kept   = cam_data_valid && (armed || pos_vs) && !e_err &&
             (hx >= e_x0) && ({1'b0, hx} < {1'b0, e_x0} + {1'b0, e_w}) &&
             (vy >= e_y0) && ({1'b0, vy} < {1'b0, e_y0} + {1'b0, e_h}) &&
             ((dx & ~({CNT_W{1'b1}} << e_hdec)) == '0) &&
             ((dy & ~({CNT_W{1'b1}} << e_vdec)) == '0);
    eol    = kept && (dx == e_lx);
  end
  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d0     <= 1'b0;
      vs_d1     <= 1'b0;
      hs_d0     <= 1'b0;
      hs_d1     <= 1'b0;
      h_cnt     <= '0;
      v_cnt     <= '0;
      armed     <= 1'b0;
      x0        <= CNT_W'(DEF_X0);
      y0        <= CNT_W'(DEF_Y0);
      w         <= CNT_W'(DEF_W);
      h         <= CNT_W'(DEF_H);
      hdec      <= 2'd0;
      vdec      <= 2'd0;
      last_x    <= CNT_W'(DEF_W - 1);
      last_y    <= CNT_W'(DEF_H - 1);
      out_width <= CNT_W'(DEF_W);
      err       <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      out_eof   <= 1'b0;
    end else begin
      vs_d0     <= cam_vsync;
      vs_d1     <= vs_d0;
      hs_d0     <= cam_href;
      hs_d1     <= hs_d0;
      h_cnt     <= (pos_vs | neg_hs) ? CNT_W'(cam_data_valid) : h_cnt + CNT_W'(cam_data_valid & ~&h_cnt);
      v_cnt     <= pos_vs ? '0 : neg_hs ? v_inc : v_cnt;
      armed     <= armed | pos_vs;
      if (pos_vs) begin
        x0        <= cfg_x0;
        y0        <= cfg_y0;
        w         <= cfg_w;
        h         <= cfg_h;
        hdec      <= cfg_hdec;
        vdec      <= cfg_vdec;
        last_x    <= n_lx;
        last_y    <= n_ly;
        out_width <= n_ow;
        err       <= n_err;
      end
      out_valid <= kept;
      out_data  <= kept ? cam_data : '0;
      out_sof   <= kept && (dx == '0) && (dy == '0);
      out_eol   <= eol;
      out_eof   <= eol && (dy == e_ly);
    end
  end
  assign cfg_err = err;
endmodule

// File: tb/tb_cmos_window_crop.sv
// tb_cmos_window_crop: directed frames on a 32x16 sensor against a per-pixel reference model
module tb_cmos_window_crop;
  localparam int DW = 16, CW = 12, IW = 32, IH = 16;
  logic cam_pclk = 0, rst_n = 0, cam_vsync = 0, cam_href = 0, cam_data_valid = 0;
  logic [DW-1:0] cam_data = '0;
  logic [CW-1:0] cfg_x0 = 4, cfg_y0 = 2, cfg_w = 24, cfg_h = 12;
  logic [1:0] cfg_hdec = 0, cfg_vdec = 0;
  logic out_valid, out_sof, out_eol, out_eof, cfg_err;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_width;
  int total = 0, bad = 0;
  int mism, n_v, n_sof, n_eol, n_eof, mx0, my0, mw, mh, mhs, mvs;
  time fb_t;
  bit merr, m_armed = 0;
  logic e_v = 0, e_sof = 0, e_eol = 0, e_eof = 0;
  logic [DW-1:0] e_d = '0, sof_data;
  cmos_window_crop #(.DATA_W(DW), .CNT_W(CW), .IN_W(IW), .IN_H(IH),
    .DEF_X0(4), .DEF_Y0(2), .DEF_W(24), .DEF_H(12)) dut (
    .cam_pclk(cam_pclk), .rst_n(rst_n), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_data(cam_data), .cam_data_valid(cam_data_valid),
    .cfg_x0(cfg_x0), .cfg_y0(cfg_y0), .cfg_w(cfg_w), .cfg_h(cfg_h),
    .cfg_hdec(cfg_hdec), .cfg_vdec(cfg_vdec),
    .out_valid(out_valid), .out_data(out_data), .out_sof(out_sof), .out_eol(out_eol),
    .out_eof(out_eof), .out_width(out_width), .cfg_err(cfg_err));
  always #5 cam_pclk = ~cam_pclk;
  // Checks the previous beat's expected outputs, then applies the next beat.
  task automatic tick(input logic r, vs, hs, dv, input logic [DW-1:0] d, input logic k, sf, el, ef);
    @(posedge cam_pclk);
    #1;
    if (out_valid !== e_v || out_sof !== e_sof || out_eol !== e_eol || out_eof !== e_eof ||
        out_data !== (e_v ? e_d : '0) || (!rst_n && (out_width !== 12'd24 || cfg_err !== 1'b0))) begin
      if (mism == 0) fb_t = $time;
      mism++;
    end
    n_v += int'(out_valid);
    n_sof += int'(out_sof);
    n_eol += int'(out_eol);
    n_eof += int'(out_eof);
    if (out_sof === 1'b1) sof_data = out_data;
    rst_n = r; cam_vsync = vs; cam_href = hs; cam_data_valid = dv; cam_data = d;
    e_v = k; e_sof = sf; e_eol = el; e_eof = ef; e_d = d;
  endtask
  task automatic pix(input int x, input int y, input bit gap, input logic r);
    int dx, dy;
    bit k, el;
    dx = x - mx0;
    dy = y - my0;
    if (!r) m_armed = 0;
    if (gap) repeat (1 + $urandom_range(0, 3)) tick(r, 0, 1, 0, '0, 0, 0, 0, 0);
    k = m_armed && !merr && dx >= 0 && dx < mw && dy >= 0 && dy < mh && dx % mhs == 0 && dy % mvs == 0;
    el = k && dx == (mw - 1) / mhs * mhs;
    tick(r, 0, 1, 1, DW'({y[7:0], x[7:0]}), k, k && dx == 0 && dy == 0, el, el && dy == (mh - 1) / mvs * mvs);
  endtask
  task automatic frame(input bit gap, input int chg_y, input int rst_y);
    mism = 0; n_v = 0; n_sof = 0; n_eol = 0; n_eof = 0; sof_data = '0;
    mx0 = int'(cfg_x0); my0 = int'(cfg_y0); mw = int'(cfg_w); mh = int'(cfg_h);
    mhs = 1 << cfg_hdec; mvs = 1 << cfg_vdec;
    merr = mw == 0 || mh == 0 || mx0 + mw > IW || my0 + mh > IH;
    repeat (3) tick(1, 1, 0, 0, '0, 0, 0, 0, 0);
    m_armed = 1;
    repeat (3) tick(1, 0, 0, 0, '0, 0, 0, 0, 0);
    for (int y = 0; y < IH; y++) begin
      if (y == chg_y) cfg_x0 = 0;
      for (int x = 0; x < IW; x++) pix(x, y, gap, !(y == rst_y && x >= 4 && x < 10));
      repeat (3) tick(1, 0, 0, 0, '0, 0, 0, 0, 0);
    end
  endtask
  task automatic test_reset;
    @(posedge cam_pclk);
    #1;
    total++;
    if ({out_valid, out_sof, out_eol, out_eof, cfg_err} !== 5'b0 || out_data !== '0) begin
      bad++;
      $display("FAIL reset_outs: got valid=%b sof=%b eol=%b eof=%b err=%b data=%h, want all 0",
               out_valid, out_sof, out_eol, out_eof, cfg_err, out_data);
    end
    total++;
    if (out_width !== 12'd24) begin
      bad++;
      $display("FAIL reset_width: got %0d want 24", out_width);
    end
    rst_n = 1;
    repeat (3) tick(1, 0, 0, 0, '0, 0, 0, 0, 0);
  endtask
  task automatic test_full;
    frame(0, -1, -1);
    total++;
    if (n_v != 288 || n_sof != 1 || n_eol != 12 || n_eof != 1 || mism != 0) begin
      bad++;
      $display("FAIL full_frame: got v=%0d sof=%0d eol=%0d eof=%0d beat_errs=%0d (first at %0t), want 288/1/12/1/0",
               n_v, n_sof, n_eol, n_eof, mism, fb_t);
    end
    total++;
    if (sof_data !== 16'h0204 || out_width !== 12'd24 || cfg_err !== 1'b0) begin
      bad++;
      $display("FAIL full_sof: got data=%h width=%0d err=%b, want 0204/24/0", sof_data, out_width, cfg_err);
    end
  endtask
  task automatic test_decimate;
    cfg_hdec = 1; cfg_vdec = 1;
    frame(0, -1, -1);
    total++;
    if (n_v != 72 || n_sof != 1 || n_eol != 6 || n_eof != 1 || mism != 0) begin
      bad++;
      $display("FAIL dec_frame: got v=%0d sof=%0d eol=%0d eof=%0d beat_errs=%0d (first at %0t), want 72/1/6/1/0",
               n_v, n_sof, n_eol, n_eof, mism, fb_t);
    end
    total++;
    if (out_width !== 12'd12) begin
      bad++;
      $display("FAIL dec_width: got %0d want 12", out_width);
    end
  endtask
  task automatic test_edge;
    cfg_x0 = 8; cfg_y0 = 4; cfg_hdec = 2; cfg_vdec = 0;
    frame(0, -1, -1);
    total++;
    if (n_v != 72 || n_sof != 1 || n_eol != 12 || n_eof != 1 || mism != 0 || cfg_err !== 1'b0) begin
      bad++;
      $display("FAIL edge_frame: got v=%0d sof=%0d eol=%0d eof=%0d beat_errs=%0d err=%b, want 72/1/12/1/0/0",
               n_v, n_sof, n_eol, n_eof, mism, cfg_err);
    end
    total++;
    if (out_width !== 12'd6 || sof_data !== 16'h0408) begin
      bad++;
      $display("FAIL edge_width: got width=%0d sof_data=%h, want 6/0408", out_width, sof_data);
    end
  endtask
  task automatic test_cfg_shadow;
    cfg_x0 = 4; cfg_y0 = 2; cfg_hdec = 0;
    frame(0, 5, -1);
    total++;
    if (n_v != 288 || n_eol != 12 || n_eof != 1 || mism != 0 || sof_data !== 16'h0204) begin
      bad++;
      $display("FAIL shadow_cur: got v=%0d eol=%0d eof=%0d beat_errs=%0d sof_data=%h, want 288/12/1/0/0204",
               n_v, n_eol, n_eof, mism, sof_data);
    end
    frame(0, -1, -1);
    total++;
    if (n_v != 288 || n_eol != 12 || n_eof != 1 || mism != 0 || sof_data !== 16'h0200) begin
      bad++;
      $display("FAIL shadow_next: got v=%0d eol=%0d eof=%0d beat_errs=%0d sof_data=%h, want 288/12/1/0/0200",
               n_v, n_eol, n_eof, mism, sof_data);
    end
  endtask
  task automatic test_err;
    cfg_x0 = 20;
    frame(0, -1, -1);
    total++;
    if (n_v != 0 || mism != 0 || cfg_err !== 1'b1) begin
      bad++;
      $display("FAIL err_xbound: got v=%0d beat_errs=%0d err=%b, want 0/0/1", n_v, mism, cfg_err);
    end
    cfg_x0 = 4; cfg_w = 0;
    frame(0, -1, -1);
    total++;
    if (n_v != 0 || mism != 0 || cfg_err !== 1'b1) begin
      bad++;
      $display("FAIL err_zero_w: got v=%0d beat_errs=%0d err=%b, want 0/0/1", n_v, mism, cfg_err);
    end
    cfg_w = 24;
    frame(0, -1, -1);
    total++;
    if (n_v != 288 || n_eof != 1 || mism != 0 || cfg_err !== 1'b0) begin
      bad++;
      $display("FAIL err_restore: got v=%0d eof=%0d beat_errs=%0d err=%b, want 288/1/0/0", n_v, n_eof, mism, cfg_err);
    end
  endtask
  task automatic test_mid_reset;
    frame(0, -1, 6);
    total++;
    if (n_v != 96 || n_sof != 1 || n_eol != 4 || n_eof != 0 || mism != 0) begin
      bad++;
      $display("FAIL midrst_frame: got v=%0d sof=%0d eol=%0d eof=%0d beat_errs=%0d (first at %0t), want 96/1/4/0/0",
               n_v, n_sof, n_eol, n_eof, mism, fb_t);
    end
    frame(0, -1, -1);
    total++;
    if (n_v != 288 || n_sof != 1 || n_eol != 12 || n_eof != 1 || mism != 0) begin
      bad++;
      $display("FAIL midrst_next: got v=%0d sof=%0d eol=%0d eof=%0d beat_errs=%0d, want 288/1/12/1/0",
               n_v, n_sof, n_eol, n_eof, mism);
    end
  endtask
  task automatic test_gaps;
    frame(1, -1, -1);
    total++;
    if (n_v != 288 || n_sof != 1 || n_eol != 12 || n_eof != 1 || mism != 0 || sof_data !== 16'h0204) begin
      bad++;
      $display("FAIL gap_frame: got v=%0d sof=%0d eol=%0d eof=%0d beat_errs=%0d sof_data=%h, want 288/1/12/1/0/0204",
               n_v, n_sof, n_eol, n_eof, mism, sof_data);
    end
  endtask
  initial begin
    test_reset;
    test_full;
    test_decimate;
    test_edge;
    test_cfg_shadow;
    test_err;
    test_mid_reset;
    test_gaps;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
